// File: rtl/scan_gen.sv
// Digit-scan timing for the 4-digit 7-segment path: prescaled scan index plus a frame-sampled, saturated display value.
// Latency: all outputs registered; in14 reaches out14 at the next frame edge (<= 4*(DIV_MAX+1) clocks) or 1 clock via in_load.
// Backpressure: none; free-running producer-side stage, in_hold freezes the sampled value, in_load restarts the scan.
module scan_gen #(
   parameter int DIV_W   = 16,
   parameter int DIV_MAX = 12499,
   parameter int MAXVAL  = 9999
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [13:0] in14,
   input  logic        in_hold,
   input  logic        in_load,
   output logic [13:0] out14,
   output logic [1:0]  out2_scan,
   output logic        out_tick,
   output logic        out_frame
);

   localparam logic [DIV_W-1:0] DIV_TERM = DIV_W'(DIV_MAX);
   localparam logic [13:0]      SAT_LIM  = 14'(MAXVAL);
   localparam logic [1:0]       LAST_IDX = 2'd3;

   logic [DIV_W-1:0] div_cnt;
   logic             div_term;
   logic             frame_edge;
   logic [13:0]      sat_dat;

   // Terminal count of the prescaler marks a scan advance; the advance out of
   // the last digit is the frame boundary where a new value may be latched.
   always_comb begin
      div_term   = (div_cnt == DIV_TERM);
      frame_edge = div_term && (out2_scan == LAST_IDX);
      sat_dat    = (in14 > SAT_LIM) ? SAT_LIM : in14;
   end

   // Prescaler: counts 0..DIV_MAX, restarts on wrap or on a load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (in_load || div_term) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= DIV_W'(div_cnt + 1'b1);
      end
   end

   // Scan index and its registered tick/frame pulses; a load suppresses the
   // pulse that the same edge would otherwise have produced.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out2_scan <= 2'd0;
         out_tick  <= 1'b0;
         out_frame <= 1'b0;
      end else if (in_load) begin
         out2_scan <= 2'd0;
         out_tick  <= 1'b0;
         out_frame <= 1'b0;
      end else begin
         out_tick  <= div_term;
         out_frame <= frame_edge;
         if (div_term) begin
            out2_scan <= 2'(out2_scan + 2'd1);
         end
      end
   end

   // Displayed value only moves on a frame boundary (unless held) or a load,
   // so the decoder never shows digits from two different samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out14 <= 14'd0;
      end else if (in_load) begin
         out14 <= sat_dat;
      end else if (frame_edge && !in_hold) begin
         out14 <= sat_dat;
      end
   end

endmodule

// File: tb/tb_scan_gen.sv
// Directed bench for scan_gen: DIV_MAX=3 instance for scan/sample/load/reset, DIV_MAX=0 instance for the degenerate prescaler.
// Latency: outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Backpressure: none; fixed-length stimulus, no waits on DUT events.
module tb_scan_gen;

   logic        clk;
   logic        rst_n;
   logic [13:0] in14;
   logic        in_hold;
   logic        in_load;

   logic [13:0] out14_3;
   logic [1:0]  scan_3;
   logic        tick_3;
   logic        frame_3;

   logic [13:0] out14_0;
   logic [1:0]  scan_0;
   logic        tick_0;
   logic        frame_0;

   int checks;
   int errors;
   int ecnt;

   scan_gen #(.DIV_W(16), .DIV_MAX(3), .MAXVAL(9999)) u_dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in14      (in14),
      .in_hold   (in_hold),
      .in_load   (in_load),
      .out14     (out14_3),
      .out2_scan (scan_3),
      .out_tick  (tick_3),
      .out_frame (frame_3)
   );

   scan_gen #(.DIV_W(16), .DIV_MAX(0), .MAXVAL(9999)) u_dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in14      (in14),
      .in_hold   (in_hold),
      .in_load   (1'b0),
      .out14     (out14_0),
      .out2_scan (scan_0),
      .out_tick  (tick_0),
      .out_frame (frame_0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d (edge %0d)", tag, got, exp, ecnt);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      ecnt++;
   endtask

   task automatic run_to(input int target);
      while (ecnt < target) step();
   endtask

   initial begin
      int exp_scan;
      int exp_tick;
      int exp_frame;
      int exp_out;

      checks  = 0;
      errors  = 0;
      ecnt    = 0;
      rst_n   = 1'b0;
      in14    = 14'd0;
      in_hold = 1'b0;
      in_load = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out14", out14_3, 0);
      check("rst_scan",  scan_3,  0);
      check("rst_tick",  tick_3,  0);
      check("rst_frame", frame_3, 0);
      rst_n = 1'b1;
      ecnt  = 0;

      // free-run sweep: index advances every 4 edges, frame only on 3->0
      for (int e = 1; e <= 20; e++) begin
         step();
         exp_tick  = (ecnt % 4 == 0) ? 1 : 0;
         exp_scan  = (ecnt / 4) % 4;
         exp_frame = (exp_tick == 1 && exp_scan == 0) ? 1 : 0;
         check("sweep_scan",  scan_3,  exp_scan);
         check("sweep_tick",  tick_3,  exp_tick);
         check("sweep_frame", frame_3, exp_frame);
         check("sweep_out14", out14_3, 0);
      end

      // sampling and saturation: frame edges at 32 and 48
      in14 = 14'd1234;
      for (int e = 21; e <= 48; e++) begin
         if (e == 38) in14 = 14'd12000;
         step();
         if (ecnt < 32)      exp_out = 0;
         else if (ecnt < 48) exp_out = 1234;
         else                exp_out = 9999;
         check("sample_out14", out14_3, exp_out);
      end

      // hold: reload 1234 at edge 64, freeze over 80/96/112, release -> 42 at 128
      in14 = 14'd1234;
      run_to(64);
      check("hold_pre", out14_3, 1234);
      in_hold = 1'b1;
      in14    = 14'd42;
      for (int e = 65; e <= 112; e++) begin
         step();
         check("hold_frozen", out14_3, 1234);
      end
      in_hold = 1'b0;
      for (int e = 113; e <= 128; e++) begin
         step();
         exp_out = (ecnt < 128) ? 1234 : 42;
         check("hold_release", out14_3, exp_out);
      end
      check("hold_frame128", frame_3, 1);

      // load collision on the edge where div_cnt==3 and scan==3 (edge 144)
      run_to(143);
      check("coll_pre_scan", scan_3, 3);
      in_load = 1'b1;
      in14    = 14'd16383;
      step();
      check("coll_out14", out14_3, 9999);
      check("coll_scan",  scan_3,  0);
      check("coll_tick",  tick_3,  0);
      check("coll_frame", frame_3, 0);

      // held load re-samples every cycle and ignores in_hold
      in14 = 14'd500;
      step();
      check("load_hold_out14", out14_3, 500);
      check("load_hold_scan",  scan_3,  0);
      in_hold = 1'b1;
      in14    = 14'd10000;
      step();
      check("load_ign_hold", out14_3, 9999);
      check("load_ign_tick", tick_3,  0);

      // after load: prescaler restarted at 0, first tick 4 edges later
      in_load = 1'b0;
      in_hold = 1'b0;
      in14    = 14'd7;
      for (int k = 1; k <= 4; k++) begin
         step();
         check("post_load_tick", tick_3, (k == 4) ? 1 : 0);
         check("post_load_scan", scan_3, (k == 4) ? 1 : 0);
      end
      check("post_load_out14", out14_3, 9999);

      // asynchronous reset mid-count, observed before the next edge
      step();
      step();
      rst_n = 1'b0;
      #2;
      check("arst_out14", out14_3, 0);
      check("arst_scan",  scan_3,  0);
      check("arst_tick",  tick_3,  0);
      check("arst_frame", frame_3, 0);
      check("arst0_scan", scan_0,  0);
      check("arst0_tick", tick_0,  0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // release: DIV_MAX=3 ticks at edge 4; DIV_MAX=0 ticks every edge
      for (int k = 1; k <= 8; k++) begin
         step();
         check("rel_tick",   tick_3,  (k % 4 == 0) ? 1 : 0);
         check("rel_scan",   scan_3,  (k / 4) % 4);
         check("div0_tick",  tick_0,  1);
         check("div0_scan",  scan_0,  k % 4);
         check("div0_frame", frame_0, (k % 4 == 0) ? 1 : 0);
         check("div0_out14", out14_0, (k >= 4) ? 7 : 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
